// File: rtl/servo_pwm_pkg.sv
// ---------------------------------------------------------------------------
// servo_pwm_pkg
// Shared types and defaults for the servo PWM generator:
//   state_t    - controller states (idle / run / drain)
//   pw_t       - 16-bit pulse width in microseconds
//   DEF_*      - default frame period and pulse clamp limits
//   clamp_pw() - clamp rule applied when a new width set is accepted
// ---------------------------------------------------------------------------
package servo_pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef logic [15:0] pw_t;

  localparam int DEF_FRAME_US = 20000;
  localparam int DEF_MIN_US   = 500;
  localparam int DEF_MAX_US   = 2500;

  // Zero means "channel off" and is kept; anything else is forced into [lo, hi].
  function automatic pw_t clamp_pw(input pw_t v, input pw_t lo, input pw_t hi);
    pw_t r;
    if (v == 16'd0) begin
      r = 16'd0;
    end else if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/servo_pwm_cmp.sv
// ---------------------------------------------------------------------------
// servo_pwm_cmp
// One servo channel: holds the active pulse width and produces the
// registered PWM output by comparing it with the shared microsecond counter.
//   clk, rst    - clock and asynchronous active-high reset
//   load        - copy load_value into the active width this cycle
//   load_value  - new width (already clamped)
//   run         - generator is not idle; output forced low otherwise
//   us_cnt      - position within the frame in microseconds
//   pwm         - registered pulse output
// ---------------------------------------------------------------------------
module servo_pwm_cmp
  import servo_pwm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  pw_t  load_value,
  input  logic run,
  input  pw_t  us_cnt,
  output logic pwm
);

  pw_t active;

  // Active width register; only changes when the top says a frame starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 16'd0;
    end else if (load) begin
      active <= load_value;
    end else begin
      active <= active;
    end
  end

  // Output flop; an active width of 0 never satisfies the compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= run && (us_cnt < active);
    end
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// ---------------------------------------------------------------------------
// servo_pwm_gen
// Multi-channel hobby-servo PWM generator. A prescaler derives a 1 us tick
// from ACLK, a frame counter counts microseconds within the frame, and each
// channel compares that count with its active width. New widths are offered
// through a one-deep pending slot and only take effect at a frame boundary
// (or when the generator starts), so pulses are never cut or stretched.
//   ACLK, ARESET - clock and asynchronous active-high reset
//   enable       - run request; dropping it lets the current frame finish
//   pw_us        - requested widths, channel i in bits [16i+15:16i]
//   pw_valid     - strobe offering pw_us, taken only while pw_ready is high
//   pw_ready     - pending slot empty
//   pwm_out      - registered servo pulses, one bit per channel
//   frame_tick   - one-cycle pulse as each new frame begins
// ---------------------------------------------------------------------------
module servo_pwm_gen
  import servo_pwm_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int N_CH        = 4,
  parameter int FRAME_US    = DEF_FRAME_US,
  parameter int MIN_US      = DEF_MIN_US,
  parameter int MAX_US      = DEF_MAX_US
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              enable,
  input  logic [N_CH*16-1:0] pw_us,
  input  logic              pw_valid,
  output logic              pw_ready,
  output logic [N_CH-1:0]   pwm_out,
  output logic              frame_tick
);

  localparam int PRESC   = CLK_FREQ_HZ / 1000000;
  localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);
  localparam pw_t FRAME_LAST = pw_t'(FRAME_US - 1);
  localparam pw_t MIN_PW     = pw_t'(MIN_US);
  localparam pw_t MAX_PW     = pw_t'(MAX_US);

  state_t             state;
  state_t             next_state;
  logic [PRESC_W-1:0] presc;
  pw_t                us_cnt;
  pw_t                pending [N_CH];
  logic               run;
  logic               us_tick;
  logic               boundary;
  logic               start;
  logic               frame_event;
  logic               load;

  assign run      = (state != ST_IDLE);
  assign us_tick  = run && (presc == PRESC_LAST);
  assign boundary = us_tick && (us_cnt == FRAME_LAST);
  assign start    = (state == ST_IDLE) && enable;
  // A boundary that ends in IDLE (drain finished) is not a new frame.
  assign frame_event = boundary && (next_state != ST_IDLE);
  // pw_ready low means the slot holds a value waiting to become active.
  assign load = !pw_ready && (start || frame_event);

  // Next-state logic; drain only exits to idle on a frame boundary.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (enable) next_state = ST_RUN;
        else        next_state = ST_IDLE;
      end
      ST_RUN: begin
        if (!enable) next_state = ST_DRAIN;
        else         next_state = ST_RUN;
      end
      ST_DRAIN: begin
        if (enable)        next_state = ST_RUN;
        else if (boundary) next_state = ST_IDLE;
        else               next_state = ST_DRAIN;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Prescaler and microsecond frame counter; both parked at zero in idle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      presc  <= '0;
      us_cnt <= 16'd0;
    end else if (!run) begin
      presc  <= '0;
      us_cnt <= 16'd0;
    end else if (us_tick) begin
      presc  <= '0;
      us_cnt <= boundary ? 16'd0 : (us_cnt + 16'd1);
    end else begin
      presc  <= presc + PRESC_W'(1);
      us_cnt <= us_cnt;
    end
  end

  // Pending slot: accept and clamp when empty, empty again when applied.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      pw_ready <= 1'b1;
      for (int i = 0; i < N_CH; i++) pending[i] <= 16'd0;
    end else if (pw_valid && pw_ready) begin
      pw_ready <= 1'b0;
      for (int i = 0; i < N_CH; i++) pending[i] <= clamp_pw(pw_us[16*i +: 16], MIN_PW, MAX_PW);
    end else if (load) begin
      pw_ready <= 1'b1;
    end else begin
      pw_ready <= pw_ready;
    end
  end

  // Frame tick marks the first cycle of each new frame.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_event;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    servo_pwm_cmp u_cmp (
      .clk        (ACLK),
      .rst        (ARESET),
      .load       (load),
      .load_value (pending[g]),
      .run        (run),
      .us_cnt     (us_cnt),
      .pwm        (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// ---------------------------------------------------------------------------
// tb_servo_pwm_gen
// Directed plus randomized bench for servo_pwm_gen at 4 MHz, 200 us frames,
// 50..150 us clamp. A frame-level reference model predicts, per clock, the
// pulse outputs, frame_tick and pw_ready from the timing rules: frames start
// when the generator starts and every 800 clocks after, a width set becomes
// active at the first frame start after the clock that accepted it.
// ---------------------------------------------------------------------------
module tb_servo_pwm_gen;

  localparam int CLK_PER_US = 4;
  localparam int FRAME_CLK  = 200 * CLK_PER_US;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        enable;
  logic [63:0] pw_us;
  logic        pw_valid;
  logic        pw_ready;
  logic [3:0]  pwm_out;
  logic        frame_tick;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int cyc = 0;
  bit running = 1'b0;
  bit draining = 1'b0;
  int run_base = 0;
  int m_act [4];
  int m_pend [4];
  bit m_full = 1'b0;
  int acc [4];
  int last_hi [4];
  int n_ticks = 0;

  servo_pwm_gen #(
    .CLK_FREQ_HZ (4000000),
    .N_CH        (4),
    .FRAME_US    (200),
    .MIN_US      (50),
    .MAX_US      (150)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .enable     (enable),
    .pw_us      (pw_us),
    .pw_valid   (pw_valid),
    .pw_ready   (pw_ready),
    .pwm_out    (pwm_out),
    .frame_tick (frame_tick)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_clamp(input int v);
    if (v == 0) return 0;
    if (v < 50) return 50;
    if (v > 150) return 150;
    return v;
  endfunction

  // One clock: advance the model by the edge, then check the DUT just after it.
  task automatic step();
    logic [3:0] e_pwm;
    bit e_tick;
    bit bnd;
    bit apply;
    int ucnt;
    @(posedge ACLK);
    cyc++;
    e_pwm = 4'b0000;
    e_tick = 1'b0;
    apply = 1'b0;
    if (ARESET) begin
      running = 1'b0;
      draining = 1'b0;
      m_full = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_act[i] = 0;
        m_pend[i] = 0;
        acc[i] = 0;
      end
    end else begin
      if (running) begin
        ucnt = ((cyc - 1 - run_base) % FRAME_CLK) / CLK_PER_US;
        for (int i = 0; i < 4; i++) e_pwm[i] = (ucnt < m_act[i]);
      end
      bnd = running && (((cyc - run_base) % FRAME_CLK) == 0);
      if (!running) begin
        if (enable) begin
          running = 1'b1;
          draining = 1'b0;
          run_base = cyc;
          apply = m_full;
          for (int i = 0; i < 4; i++) acc[i] = 0;
        end
      end else begin
        if (bnd) begin
          if (draining && !enable) begin
            running = 1'b0;
          end else begin
            e_tick = 1'b1;
            apply = m_full;
          end
        end
        if (running) draining = !enable;
      end
      if (apply) begin
        for (int i = 0; i < 4; i++) m_act[i] = m_pend[i];
        m_full = 1'b0;
      end else if (pw_valid && !m_full) begin
        for (int i = 0; i < 4; i++) m_pend[i] = ref_clamp(int'(pw_us[16*i +: 16]));
        m_full = 1'b1;
      end
    end
    #1;
    chk("pwm_out", {28'd0, pwm_out}, {28'd0, e_pwm});
    chk("frame_tick", {31'd0, frame_tick}, {31'd0, e_tick});
    chk("pw_ready", {31'd0, pw_ready}, {31'd0, !m_full});
    for (int i = 0; i < 4; i++) acc[i] += int'(pwm_out[i]);
    if (e_tick) begin
      n_ticks++;
      for (int i = 0; i < 4; i++) begin
        last_hi[i] = acc[i];
        acc[i] = 0;
      end
    end
  endtask

  task automatic send(input int a, input int b, input int c, input int d);
    pw_us = {d[15:0], c[15:0], b[15:0], a[15:0]};
    pw_valid = 1'b1;
    step();
    pw_valid = 1'b0;
  endtask

  // Advance to the clock at the given offset (in clocks) within the running frame.
  task automatic goto(input int off);
    int guard = 0;
    do begin
      step();
      guard++;
    end while (!(running && (((cyc - run_base) % FRAME_CLK) == off)) && guard < 3 * FRAME_CLK);
  endtask

  task automatic run_frames(input int n);
    int target = n_ticks + n;
    int guard = 0;
    while (n_ticks < target && guard < (n + 1) * FRAME_CLK) begin
      step();
      guard++;
    end
  endtask

  function automatic int rnd_pw();
    case ($urandom_range(0, 3))
      0: return 0;
      1: return $urandom_range(1, 49);
      2: return $urandom_range(50, 150);
      default: return $urandom_range(151, 65535);
    endcase
  endfunction

  initial begin
    ARESET = 1'b1;
    enable = 1'b0;
    pw_valid = 1'b0;
    pw_us = 64'd0;
    for (int i = 0; i < 4; i++) begin
      m_act[i] = 0;
      m_pend[i] = 0;
      acc[i] = 0;
      last_hi[i] = 0;
    end
    repeat (3) step();
    ARESET = 1'b0;
    repeat (5) step();

    // widths accepted while idle, outputs stay quiet
    send(100, 75, 150, 0);
    chk("idle_pw_ready", {31'd0, pw_ready}, 32'd0);
    repeat (20) step();
    chk("idle_pwm", {28'd0, pwm_out}, 32'd0);

    // start: pending applied at once, 400/300/600/0 clocks per frame
    enable = 1'b1;
    run_frames(2);
    chk("run_ch0", last_hi[0], 400);
    chk("run_ch1", last_hi[1], 300);
    chk("run_ch2", last_hi[2], 600);
    chk("run_ch3", last_hi[3], 0);

    // mid-frame update waits for the boundary; second offer while busy is dropped
    goto(80);
    send(60, 75, 150, 0);
    chk("upd_ready_low", {31'd0, pw_ready}, 32'd0);
    goto(400);
    send(140, 140, 140, 140);
    run_frames(1);
    chk("upd_cur_frame", last_hi[0], 400);
    run_frames(1);
    chk("upd_next_frame", last_hi[0], 240);
    chk("upd_ignored", last_hi[1], 300);

    // clamp below minimum and above maximum
    goto(300);
    send(10, 9999, 150, 0);
    run_frames(2);
    chk("clamp_lo", last_hi[0], 200);
    chk("clamp_hi", last_hi[1], 600);

    // offer on the frame_tick cycle: not used until one frame later
    goto(0);
    send(120, 75, 150, 0);
    run_frames(1);
    chk("tick_offer_old", last_hi[0], 200);
    run_frames(1);
    chk("tick_offer_new", last_hi[0], 480);

    // offer sampled on the boundary clock itself is deferred a frame
    goto(FRAME_CLK - 1);
    send(70, 75, 150, 0);
    run_frames(1);
    chk("bnd_offer_old", last_hi[0], 480);
    run_frames(1);
    chk("bnd_offer_new", last_hi[0], 280);

    // randomized offers at random points in the frame
    for (int k = 0; k < 6; k++) begin
      goto($urandom_range(0, FRAME_CLK - 1));
      send(rnd_pw(), rnd_pw(), rnd_pw(), rnd_pw());
      repeat ($urandom_range(0, 900)) step();
    end

    // drain: frame completes with whole pulses, then idle
    run_frames(1);
    send(100, 75, 150, 0);
    run_frames(2);
    goto(120);
    enable = 1'b0;
    repeat (FRAME_CLK - 100) step();
    chk("drain_idle_pwm", {28'd0, pwm_out}, 32'd0);
    chk("drain_ch0", acc[0], 400);
    chk("drain_ch1", acc[1], 300);
    chk("drain_ch2", acc[2], 600);

    // re-enable during drain continues the same frame
    enable = 1'b1;
    goto(120);
    enable = 1'b0;
    repeat (200) step();
    enable = 1'b1;
    run_frames(1);
    chk("redrain_ch0", last_hi[0], 400);
    chk("redrain_ch2", last_hi[2], 600);

    // asynchronous reset in the middle of a pulse
    goto(80);
    chk("pre_reset_pwm", {28'd0, pwm_out}, 32'd7);
    ARESET = 1'b1;
    #1;
    chk("async_reset_pwm", {28'd0, pwm_out}, 32'd0);
    chk("async_reset_tick", {31'd0, frame_tick}, 32'd0);
    chk("async_reset_ready", {31'd0, pw_ready}, 32'd1);
    repeat (3) step();
    ARESET = 1'b0;
    send(90, 60, 150, 0);
    run_frames(2);
    chk("post_reset_ch0", last_hi[0], 360);
    chk("post_reset_ch1", last_hi[1], 240);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/servo_pwm_gen.md
SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100000000: ACLK frequency; must be an integer multiple of 1 MHz.
REQ-002 SHALL have parameter N_CH, default 4: number of servo channels, matching the 4 AXI-Lite slave registers.
REQ-003 SHALL have parameter FRAME_US, default 20000: PWM frame period in microseconds (50 Hz).
REQ-004 SHALL have parameters MIN_US, default 500, and MAX_US, default 2500: pulse-width clamp limits in microseconds.
REQ-005 SHALL have port ACLK, input, 1 bit: the single clock.
REQ-006 SHALL have port ARESET, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: run request, driven from AXI register bit.
REQ-008 SHALL have port pw_us, input, N_CH*16 bits: requested pulse widths in µs; channel i occupies bits [16i+15:16i].
REQ-009 SHALL have port pw_valid, input, 1 bit: single-cycle strobe offering pw_us.
REQ-010 SHALL have port pw_ready, output, 1 bit: high when the pending slot is empty.
REQ-011 SHALL have port pwm_out, output, N_CH bits: registered servo pulse outputs.
REQ-012 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-013 Prescaler SHALL count 0..CLK_FREQ_HZ/1e6-1 and assert internal us_tick for one cycle at terminal count; it SHALL be held at 0 in IDLE.
REQ-014 Frame counter us_cnt SHALL count 0..FRAME_US-1, advancing on us_tick; the boundary is us_tick with us_cnt=FRAME_US-1.
REQ-015 pw_valid SHALL be accepted only when pw_ready=1; on acceptance the clamped values load the pending slot and pw_ready drops the next cycle. pw_valid with pw_ready=0 SHALL be ignored.
REQ-016 Clamp on acceptance: 0 stays 0 (channel off); 1..MIN_US-1 becomes MIN_US; values above MAX_US become MAX_US; all others pass unchanged.
REQ-017 At a frame boundary in RUN: us_cnt wraps to 0, frame_tick=1 for that cycle, and if the slot is pending it is copied to active and pw_ready=1 the next cycle.
REQ-018 pw_valid accepted on the boundary cycle itself SHALL NOT be applied at that boundary; it is applied at the following boundary.
REQ-019 pwm_out[i] SHALL be registered as (state≠IDLE && us_cnt<active[i]); latency is 1 ACLK from us_cnt change. An active value of 0 gives a constant low output.
REQ-020 State machine SHALL have states IDLE, RUN and DRAIN:
- IDLE→RUN when enable=1; on that transition us_cnt=0 and any pending value is applied immediately.
- RUN→DRAIN when enable=0.
- DRAIN→RUN when enable=1 (no counter restart).
- DRAIN→IDLE at the frame boundary, so no runt pulses occur.
REQ-021 In IDLE, pwm_out=0 and frame_tick=0, and pw_valid is still accepted into the pending slot.
REQ-022 The active width SHALL change only at frame boundaries or on IDLE→RUN, so no glitch occurs mid-pulse.

Reset
REQ-023 While ARESET=1: state=IDLE, counters=0, active=0, pending empty, pwm_out=0, frame_tick=0, pw_ready=1.
REQ-024 ARESET asserted mid-frame SHALL force pwm_out low asynchronously; after release the block resumes from IDLE, with enable sampled on the first clock.

Structure
REQ-025 Package servo_pwm_pkg SHALL hold the state enum (IDLE/RUN/DRAIN), the 16-bit pulse-width typedef, and the default MIN_US/MAX_US/FRAME_US constants.
REQ-026 A sub-module servo_pwm_cmp SHALL implement one channel (active register, compare, output flop) and be instantiated N_CH times.

Verification (CLK_FREQ_HZ=4000000, FRAME_US=200, MIN_US=50, MAX_US=150)
REQ-027 Reset, then enable=1 with pw_us={100,75,150,0} accepted beforehand -> pwm_out high for 400/300/600 clocks per 800-clock frame, ch3 always low, frame_tick every 800 clocks.
REQ-028 pw_us ch0=10 and ch1=9999 -> clamped widths of 50 µs (200 clocks) and 150 µs (600 clocks).
REQ-029 Update to ch0=60 mid-frame -> current frame keeps 100 µs, next frame 60 µs; pw_ready low until the boundary, and a second pw_valid while low is ignored.
REQ-030 pw_valid on the frame_tick cycle -> value appears one frame later, not at that boundary.
REQ-031 enable dropped at us_cnt=30 -> current frame completes, pulses stay whole, then IDLE with pwm_out=0; re-enable during DRAIN continues without restarting the counter.
REQ-032 ARESET pulsed at us_cnt=20 during a pulse -> pwm_out=0 immediately, and all outputs hold their reset values.
